// File: rtl/seq_array_mult_if.sv
// Handshake bundle for seq_array_mult: operand request side, product response side, clock enable.
interface seq_array_mult_if #(parameter int WIDTH = 4);
  logic                 ena;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output ena, in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  ena, in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_array_mult.sv
// Iterative WIDTH x WIDTH multiplier: one partial-product row per enabled clock,
// sign handled by multiplying magnitudes and negating the final sum.
module seq_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_array_mult_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mag_a, mag_b, abs_a, abs_b;
  logic             neg;
  logic [PW-1:0]    acc, row, sum, prod_q;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  // Unsigned view of a WIDTH-bit negative fits: -(-2^(W-1)) is 2^(W-1) unsigned.
  assign abs_a  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b  = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign row    = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
  assign sum    = acc + row;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = bus.ena;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.ena && last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.ena && bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else if (bus.ena) begin
      case (state)
        IDLE: if (accept) begin
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg   <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          // Final row folds straight into the product so the result lands on edge E+WIDTH.
          if (last) prod_q <= neg ? -sum : sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = prod_q;
endmodule
